// File: rtl/i2c_bit_ctl.sv
// Bit-level I2C master drive side: sequences START/STOP/WRITE/READ on open-drain SCL/SDA
// in four quarter-period phases, with clock-stretch and arbitration detection.
module i2c_bit_ctl #(
    parameter int unsigned DIV_G = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cmd,
    input  logic       cmd_din,
    input  logic       cmd_vld,
    output logic       cmd_rdy,
    output logic       done,
    output logic       dout,
    output logic       arb_lost,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       scl_i,
    input  logic       sda_i
);

    localparam int unsigned       CNT_W    = 16;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DIV_G - 1);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A,
        ST_B,
        ST_C,
        ST_D
    } state_t;

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [1:0]       r_cmd, w_cmd;
    logic             r_din, w_din;
    logic             r_scl, w_scl;
    logic             r_sda, w_sda;
    logic             r_done, w_done;
    logic             r_dout, w_dout;
    logic             r_arb, w_arb;
    logic             r_rdy;
    logic             w_last;
    logic [1:0]       w_drive;

    // Line levels {scl, sda} driven during each phase of each command
    function automatic logic [1:0] phase_drive(state_t st, logic [1:0] c, logic din);
        logic [1:0] v;
        v = 2'b11;
        unique case (c)
            CMD_START: begin
                unique case (st)
                    ST_C:    v = 2'b10;
                    ST_D:    v = 2'b00;
                    default: v = 2'b11;
                endcase
            end
            CMD_STOP: begin
                unique case (st)
                    ST_A:    v = 2'b00;
                    ST_B:    v = 2'b10;
                    default: v = 2'b11;
                endcase
            end
            default: begin
                unique case (st)
                    ST_A, ST_D: v = {1'b0, (c == CMD_READ) ? 1'b1 : din};
                    default:    v = {1'b1, (c == CMD_READ) ? 1'b1 : din};
                endcase
            end
        endcase
        return v;
    endfunction

    assign w_last = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cmd   <= CMD_START;
            r_din   <= 1'b0;
            r_scl   <= 1'b1;
            r_sda   <= 1'b1;
            r_done  <= 1'b0;
            r_dout  <= 1'b0;
            r_arb   <= 1'b0;
            r_rdy   <= 1'b1;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_cmd   <= w_cmd;
            r_din   <= w_din;
            r_scl   <= w_scl;
            r_sda   <= w_sda;
            r_done  <= w_done;
            r_dout  <= w_dout;
            r_arb   <= w_arb;
            r_rdy   <= (w_state == ST_IDLE);
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_cmd   = r_cmd;
        w_din   = r_din;
        w_scl   = r_scl;
        w_sda   = r_sda;
        w_done  = 1'b0;
        w_dout  = r_dout;
        w_arb   = r_arb;
        w_drive = 2'b11;

        unique case (r_state)
            ST_IDLE: begin
                if (cmd_vld) begin
                    w_cmd   = cmd;
                    w_din   = cmd_din;
                    w_arb   = 1'b0;
                    w_state = ST_A;
                    w_cnt   = CNT_LOAD;
                end
            end
            ST_A: begin
                if (w_last) begin
                    w_state = ST_B;
                    w_cnt   = CNT_LOAD;
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            ST_B: begin
                // Slave stretching SCL: hold the phase until the line is seen high
                if (!scl_i) begin
                    w_cnt = CNT_LOAD;
                end else if (w_last) begin
                    w_state = ST_C;
                    w_cnt   = CNT_LOAD;
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            ST_C: begin
                if (w_last) begin
                    if (r_cmd == CMD_WRITE || r_cmd == CMD_READ) begin
                        w_dout = sda_i;
                    end
                    if (r_cmd == CMD_WRITE && r_din && !sda_i) begin
                        // Lost arbitration: release the bus and abort without phase D
                        w_arb   = 1'b1;
                        w_done  = 1'b1;
                        w_state = ST_IDLE;
                        w_scl   = 1'b1;
                        w_sda   = 1'b1;
                    end else begin
                        w_state = ST_D;
                        w_cnt   = CNT_LOAD;
                    end
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            ST_D: begin
                if (w_last) begin
                    w_state = ST_IDLE;
                    w_done  = 1'b1;
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        // Lines hold their last level while idle
        if (w_state != ST_IDLE) begin
            w_drive = phase_drive(w_state, w_cmd, w_din);
            w_scl   = w_drive[1];
            w_sda   = w_drive[0];
        end
    end

    assign cmd_rdy  = r_rdy;
    assign done     = r_done;
    assign dout     = r_dout;
    assign arb_lost = r_arb;
    assign scl_o    = r_scl;
    assign sda_o    = r_sda;

endmodule
